// File: rtl/move_list_writer_if.sv
// Move stream in and RAM write port out of the move list writer.
// master = move generator / RAM side, slave = the writer itself.
interface move_list_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                    mv_valid;
    logic [15:0]             mv_data;
    logic                    mv_ready;
    logic [ADDR_WIDTH-1:0]   ram_address;
    logic                    ram_write;
    logic [DATA_WIDTH-1:0]   ram_writedata;
    logic [DATA_WIDTH/8-1:0] ram_byteenable;

    modport master (
        output mv_valid, mv_data,
        input  mv_ready, ram_address, ram_write, ram_writedata, ram_byteenable
    );

    modport slave (
        input  mv_valid, mv_data,
        output mv_ready, ram_address, ram_write, ram_writedata, ram_byteenable
    );
endinterface

// File: rtl/move_list_writer.sv
// Packs pairs of 16-bit moves into RAM words starting at BASE_ADDR; odd tail padded with 16'hFFFF.
// Writes are registered (one cycle after accept); the stream is never stalled while a list is open.
module move_list_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int BASE_ADDR  = 16,
    parameter int MAX_WORDS  = 70
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     list_end,
    move_list_writer_if.slave        bus,
    output logic [7:0]               move_count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, FLUSH, DONE} state_t;

    state_t                state, state_nxt;
    logic [15:0]           low_half;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic        accept;
    logic        full;
    logic        clear;
    logic        low_ld;
    logic        cnt_inc;
    logic        idx_inc;
    logic        ovf_set;
    logic        wr_nxt;
    logic [31:0] wr_word;

    assign bus.mv_ready = (state == LOW) || (state == HIGH);
    assign busy         = (state == LOW) || (state == HIGH) || (state == FLUSH);
    assign done         = (state == DONE);
    assign accept       = bus.mv_valid && bus.mv_ready;
    assign full         = (word_idx == ADDR_WIDTH'(MAX_WORDS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A same-cycle move is always handled before list_end.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        low_ld    = 1'b0;
        cnt_inc   = 1'b0;
        idx_inc   = 1'b0;
        ovf_set   = 1'b0;
        wr_nxt    = 1'b0;
        wr_word   = 32'h0;
        if (start) begin
            state_nxt = LOW;
            clear     = 1'b1;
        end else begin
            case (state)
                LOW: begin
                    if (accept && full) begin
                        ovf_set = 1'b1;
                        if (list_end) state_nxt = DONE;
                    end else if (accept) begin
                        low_ld    = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = list_end ? FLUSH : HIGH;
                    end else if (list_end) begin
                        state_nxt = DONE;
                    end
                end
                HIGH: begin
                    if (accept) begin
                        wr_nxt    = 1'b1;
                        wr_word   = {bus.mv_data, low_half};
                        idx_inc   = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = list_end ? DONE : LOW;
                    end else if (list_end) begin
                        state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    wr_nxt    = 1'b1;
                    wr_word   = {16'hFFFF, low_half};
                    idx_inc   = 1'b1;
                    state_nxt = DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_half           <= 16'h0;
            word_idx           <= '0;
            move_count         <= 8'h0;
            overflow           <= 1'b0;
            bus.ram_write      <= 1'b0;
            bus.ram_address    <= '0;
            bus.ram_writedata  <= '0;
            bus.ram_byteenable <= '0;
        end else begin
            bus.ram_write      <= wr_nxt;
            bus.ram_byteenable <= wr_nxt ? '1 : '0;
            if (wr_nxt) begin
                bus.ram_address   <= ADDR_WIDTH'(BASE_ADDR) + word_idx;
                bus.ram_writedata <= DATA_WIDTH'(wr_word);
            end
            if (clear) begin
                word_idx   <= '0;
                move_count <= 8'h0;
                overflow   <= 1'b0;
            end else begin
                if (low_ld)  low_half   <= bus.mv_data;
                if (idx_inc) word_idx   <= word_idx + 1'b1;
                if (cnt_inc) move_count <= move_count + 8'd1;
                if (ovf_set) overflow   <= 1'b1;
            end
        end
    end
endmodule

// File: doc/move_list_writer.md
MOVE_LIST_WRITER -- requirements
Module: move_list_writer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, RAM word width; ADDR_WIDTH, default 15, RAM address width; BASE_ADDR, default 16, first result word address; MAX_WORDS, default 70, result words available.
REQ-002 Clock and reset: clk, in, 1, single clock, all logic on rising edge; reset, in, 1, asynchronous, active-high.
REQ-003 Control inputs: start, in, 1, one-cycle pulse from the control block that begins a new list; list_end, in, 1, one-cycle pulse from the generator marking the end of the list, carries no data.
REQ-004 Move stream: mv_valid, in, 1, move present; mv_data, in, 16, move as [5:0] from-square, [11:6] to-square, [15:12] flags; mv_ready, out, 1, writer accepts the move.
REQ-005 RAM write port: ram_address, out, ADDR_WIDTH, word address; ram_write, out, 1, write strobe; ram_writedata, out, DATA_WIDTH, packed moves; ram_byteenable, out, DATA_WIDTH/8, all ones whenever ram_write=1.
REQ-006 Status: move_count, out, 8, moves stored; busy, out, 1, list in progress; done, out, 1, list complete; overflow, out, 1, at least one move dropped.

Function
REQ-007 A move SHALL be accepted only on a cycle where mv_valid=1 and mv_ready=1; mv_data is ignored otherwise.
REQ-008 The FSM SHALL have the states IDLE, LOW (word empty), HIGH (low half held), FLUSH and DONE.
REQ-009 mv_ready SHALL be 1 only in LOW and HIGH.
REQ-010 busy SHALL be 1 in LOW, HIGH and FLUSH; done SHALL be 1 only in DONE and SHALL hold there until the next start.
REQ-011 start in any state SHALL move the FSM to LOW and clear word_idx, move_count, overflow and done on the next edge; a list in progress is aborted and no partial word is written.
REQ-012 LOW, on accept: latch mv_data as the low half and go to HIGH.
REQ-013 HIGH, on accept: write {mv_data, low half} to BASE_ADDR+word_idx, increment word_idx, and return to LOW.
REQ-014 Each RAM write SHALL be registered: ram_write is high for exactly one cycle, the cycle after the accepting edge, with address and data stable in that cycle.
REQ-015 list_end in LOW SHALL go to DONE with no write.
REQ-016 list_end in HIGH SHALL go to FLUSH, which writes {16'hFFFF, low half} in one cycle, increments word_idx and then enters DONE.
REQ-017 When list_end and an accepted move occur in the same cycle, the move SHALL be processed first.
REQ-018 That ordering gives: LOW+move+end -> FLUSH; HIGH+move+end -> full word written, then DONE.
REQ-019 move_count SHALL increment by 1 for each stored move; list_end alone SHALL NOT change it.
REQ-020 Full: when word_idx==MAX_WORDS, moves accepted in LOW SHALL be discarded, without a write and without a count change, and overflow SHALL be set; mv_ready stays 1 so the generator never stalls.
REQ-021 list_end and start SHALL be ignored-free in IDLE: in IDLE, list_end is ignored.

Reset
REQ-022 Asserting reset SHALL immediately force: state IDLE; mv_ready, ram_write, busy, done and overflow to 0; ram_address, ram_writedata, ram_byteenable, move_count and word_idx to 0.
REQ-023 Reset asserted mid-list SHALL discard any held low half and SHALL NOT produce a write.

Verification
REQ-024 Reset: assert reset with clk stopped -> all outputs 0 without any clock edge.
REQ-025 Three-move list: start, moves 0x070C, 0x0D35, 0x0208, then list_end -> writes addr 16=0x0D35070C and addr 17=0xFFFF0208; move_count=3; done=1.
REQ-026 Empty list: start, then list_end only -> no ram_write; move_count=0; done=1; busy=0.
REQ-027 Overflow: MAX_WORDS=2, start, 5 moves, list_end -> exactly 2 writes (addr 16, 17); move_count=4; overflow=1; mv_ready never deasserted during the list.
REQ-028 Simultaneous events: in HIGH, mv_valid=1 with list_end=1 -> one full-word write, then DONE with no FLUSH write. Restart: start issued in HIGH -> no write; next list begins at addr 16 with move_count=0.
